mem_access_ctrl: RTL
====================

# mem_access_ctrl

Load/store sequencer between the core's memory stage and the byte-wide `DATA_MEMORY`. Accepts one 32-bit-capable RISC-V access per request (LB/LH/LW/LBU/LHU/SB/SH/SW) and breaks it into consecutive single-byte memory cycles, little-endian. For loads it reassembles the bytes and sign- or zero-extends the result. It returns one response pulse per request and rejects misaligned accesses without touching memory.

## Interface
- `ADDR_WIDTH`, 32, byte address width; matches `DATA_MEMORY`.
- `DATA_WIDTH`, 8, memory data width; only 8 is supported.
- `XLEN`, 32, request/response data width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request; 1 only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned.
- `req_unsigned`  in  1  zero-extend a load; ignored for word loads and for stores.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  XLEN  store data; the low bytes are used.
- `resp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `resp_rdata`  out  XLEN  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned or illegal request; valid with `resp_valid`.
- `mem_addr`  out  ADDR_WIDTH  to `DATA_MEMORY.addr`.
- `mem_data_in`  out  DATA_WIDTH  to `DATA_MEMORY.data_in`.
- `mem_we`  out  1  to `DATA_MEMORY.we`.
- `mem_data_out`  in  DATA_WIDTH  from `DATA_MEMORY.data_out`.

## Operation
- FSM states: IDLE, STORE, LOAD, RESP.
- Beat count N: 1 for byte, 2 for half, 4 for word.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, the request is accepted; address, size, data and the unsigned flag are latched.
  - Misaligned requests go to RESP with err=1. Misaligned means: half with addr[0]=1, word with addr[1:0]≠0, or size 11.
  - Otherwise a store goes to STORE and a load goes to LOAD, with beat counter=0.
- **STORE** (N cycles)
  - Per beat i: `mem_we`=1, `mem_addr`=base+i, `mem_data_in`=wdata[8i+7:8i].
  - After beat N-1, go to RESP.
- **LOAD** (N+1 cycles)
  - Cycles 0..N-1 drive `mem_addr`=base+i with `mem_we`=0.
  - The attached memory returns `mem_data_out` for an address one cycle after it is driven.
  - Cycles 1..N capture byte i-1 into bits [8(i-1)+7:8(i-1)].
  - After cycle N, go to RESP.
- **RESP** (1 cycle)
  - `resp_valid`=1.
  - `resp_rdata`: load result extended from bit 8N-1 (sign-extended, or zero-extended when unsigned). Stores and errors give 0.
  - Returns to IDLE. `req_ready`=0 in this cycle, so a request can be accepted no sooner than the cycle after RESP.
- Address arithmetic:
  - base+i is computed modulo 2^ADDR_WIDTH.
  - Alignment guarantees no carry out of bits [1:0], so no wrap occurs within an access.
- Outside STORE: `mem_we`=0. `mem_addr` and `mem_data_in` hold their last driven values.
- All outputs are registered except `req_ready`, which is decoded from state.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_we`=0, `mem_addr`=0, `mem_data_in`=0, beat counter=0.
- Let T be the handshake cycle (`req_valid`&&`req_ready` at the T edge).
  - Store: beats in cycles T+1..T+N; `resp_valid` in T+N+1.
  - Load: addresses in T+1..T+N; `resp_valid` in T+N+2.
  - Error: `resp_valid` in T+1, and `mem_we` never asserts.
- Throughput: one request per N+2 cycles (store) or N+3 cycles (load).
- `req_valid` while busy is ignored, with no latching. The requester must hold the request until `req_ready`.
- `rst` mid-operation:
  - The access is aborted immediately and no response is produced.
  - Store bytes already written stay written; there is no rollback.
  - `mem_we` drops asynchronously.
- `resp_valid` is high for exactly one cycle per accepted request.

## Structure
- Shared package `mem_ctrl_pkg`:
  - Size encodings `SIZE_B`=2'b00, `SIZE_H`=2'b01, `SIZE_W`=2'b10.
  - FSM state encoding.
  - A `beats(size)` function returning N.
- Optional sub-module `load_extend`: combinational. Takes the assembled 32-bit raw data, size and unsigned flag, and returns `resp_rdata`. It is instantiated once, and exists so it can be unit-tested alone.

## Test plan
- Reset, then SW 0xDEADBEEF @0x10 -> `mem_we`=1 on T+1..T+4 with addr/data 0x10/EF, 0x11/BE, 0x12/AD, 0x13/DE; `resp_valid`=1 and err=0 at T+5.
- LW @0x10 after the above -> `resp_rdata`=0xDEADBEEF at T+6; `mem_we` stays 0.
- Extension checks:
  - LB @0x13 -> 0xFFFFFFDE.
  - LBU @0x13 -> 0x000000DE.
  - LH @0x12 -> 0xFFFFDEAD.
  - LHU @0x12 -> 0x0000DEAD.
  - SB 0x7F @0x10 then LB @0x10 -> 0x0000007F.
- Misaligned requests (LW @0x11, SH @0x13, size 11) -> `resp_err`=1, `resp_rdata`=0 at T+1; no `mem_we`; `req_ready` back to 1 at T+2.
- `req_valid` held continuously for SW @0x20 then LW @0x20 -> `req_ready`=0 from T+1 through RESP; the second request is accepted exactly one cycle after the first `resp_valid`; LW returns the stored word.
- `rst` pulsed after 2 beats of SW 0x11223344 @0x30 -> outputs return to reset values immediately; only 0x30=44 and 0x31=33 are written; no `resp_valid`.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared size encodings, FSM state type and helpers for the
//               byte-serial load/store sequencer.
// Revision    : 1.0
// ============================================================================
package mem_ctrl_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STORE = 2'd1,
        ST_LOAD  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic [2:0] beats(input logic [1:0] size);
        case (size)
            SIZE_B:  beats = 3'd1;
            SIZE_H:  beats = 3'd2;
            default: beats = 3'd4;
        endcase
    endfunction

    // Size 11 has no legal encoding, so it is reported the same way as misalignment.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_B:  misaligned = 1'b0;
            SIZE_H:  misaligned = addr_lo[0];
            SIZE_W:  misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl_if
// Description : Request/response and byte-memory signals of the sequencer.
// Revision    : 1.0
// ============================================================================
interface mem_access_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int XLEN       = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [XLEN-1:0]       req_wdata;
    logic                  resp_valid;
    logic [XLEN-1:0]       resp_rdata;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_data_out;

    // Environment side: the requester plus the memory read-data return.
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_data_in, mem_we
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_data_in, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Sign/zero extension of an assembled little-endian load value.
// Revision    : 1.0
// ============================================================================
module load_extend
    import mem_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [XLEN-1:0] i_raw,
    input  wire logic [1:0]      i_size,
    input  wire logic            i_unsigned,
    output logic      [XLEN-1:0] o_data
);
    always_comb begin
        o_data = i_raw;
        case (i_size)
            SIZE_B:  o_data = {{(XLEN-8){i_raw[7] & ~i_unsigned}}, i_raw[7:0]};
            SIZE_H:  o_data = {{(XLEN-16){i_raw[15] & ~i_unsigned}}, i_raw[15:0]};
            default: o_data = i_raw;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Splits RISC-V loads/stores into little-endian byte cycles.
// Revision    : 1.0
// ============================================================================
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int XLEN       = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    mem_access_ctrl_if.slave bus
);
    state_t                r_state;
    logic [2:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [23:0]           r_wdata_hi;
    logic [XLEN-1:0]       r_raw;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [XLEN-1:0]       r_resp_rdata;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data_in;

    logic [2:0]            w_beats;
    logic [2:0]            w_last_idx;
    logic [2:0]            w_next_cnt;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [7:0]            w_wbyte;
    logic [XLEN-1:0]       w_raw_next;
    logic [XLEN-1:0]       w_ext;

    assign w_beats     = beats(r_size);
    assign w_last_idx  = w_beats - 3'd1;
    assign w_next_cnt  = r_cnt + 3'd1;
    assign w_next_addr = r_base + ADDR_WIDTH'(w_next_cnt);

    // Byte 0 is driven straight from the request, so only bytes 1..3 are kept.
    always_comb begin
        case (w_next_cnt)
            3'd1:    w_wbyte = r_wdata_hi[7:0];
            3'd2:    w_wbyte = r_wdata_hi[15:8];
            default: w_wbyte = r_wdata_hi[23:16];
        endcase
    end

    // Memory data lags the address by one cycle, so LOAD cycle i carries byte i-1.
    always_comb begin
        w_raw_next = r_raw;
        case (r_cnt)
            3'd1:    w_raw_next[7:0]   = bus.mem_data_out;
            3'd2:    w_raw_next[15:8]  = bus.mem_data_out;
            3'd3:    w_raw_next[23:16] = bus.mem_data_out;
            3'd4:    w_raw_next[31:24] = bus.mem_data_out;
            default: w_raw_next = r_raw;
        endcase
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .i_raw      (w_raw_next),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 3'd0;
            r_base        <= '0;
            r_size        <= SIZE_B;
            r_unsigned    <= 1'b0;
            r_wdata_hi    <= '0;
            r_raw         <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_err    <= 1'b0;
            r_resp_rdata  <= '0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_base     <= bus.req_addr;
                        r_size     <= bus.req_size;
                        r_unsigned <= bus.req_unsigned;
                        r_wdata_hi <= bus.req_wdata[31:8];
                        r_cnt      <= 3'd0;
                        r_raw      <= '0;
                        if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else if (bus.req_we) begin
                            r_state       <= ST_STORE;
                            r_mem_we      <= 1'b1;
                            r_mem_addr    <= bus.req_addr;
                            r_mem_data_in <= bus.req_wdata[7:0];
                        end else begin
                            r_state    <= ST_LOAD;
                            r_mem_addr <= bus.req_addr;
                        end
                    end
                end
                ST_STORE: begin
                    if (r_cnt == w_last_idx) begin
                        r_state      <= ST_RESP;
                        r_mem_we     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= '0;
                    end else begin
                        r_cnt         <= w_next_cnt;
                        r_mem_addr    <= w_next_addr;
                        r_mem_data_in <= w_wbyte;
                    end
                end
                ST_LOAD: begin
                    r_raw <= w_raw_next;
                    if (r_cnt == w_beats) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= w_ext;
                    end else begin
                        r_cnt <= w_next_cnt;
                        if (r_cnt != w_last_idx) begin
                            r_mem_addr <= w_next_addr;
                        end
                    end
                end
                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = (r_state == ST_IDLE);
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_err    = r_resp_err;
    assign bus.resp_rdata  = r_resp_rdata;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_data_in = r_mem_data_in;

endmodule
`default_nettype wire
